// File: rtl/prng_pkg.sv
// Shared types and defaults for the prng_accum random-word generator.
// Holds the FSM state encoding, default feedback mask/seed and the reject counter width.
package prng_pkg;

  localparam logic [31:0] DEF_POLY = 32'h80200003;
  localparam logic [31:0] DEF_SEED = 32'h00000001;
  localparam int          REJ_W    = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    HOLD = 2'd2
  } state_t;

  function automatic logic [REJ_W-1:0] sat_inc(input logic [REJ_W-1:0] v);
    return (v == {REJ_W{1'b1}}) ? v : v + REJ_W'(1);
  endfunction

endpackage

// File: rtl/prng_accum_if.sv
// Output word handshake between prng_accum (master) and its consumer (slave).
interface prng_accum_if #(
  parameter int OUT_W = 256
) ();

  // valid/ready: out_data is meaningful while out_valid is high; once raised, out_valid
  // and out_data hold until a rising edge sees out_valid && out_ready (the transfer).
  logic [OUT_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output out_data,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    output out_ready
  );

endinterface

// File: rtl/prng_lfsr_core.sv
// Galois LFSR register with step enable and seed load.
// A zero seed is replaced by SEED so the register never enters the all-zero lock-up state.
module prng_lfsr_core #(
  parameter int              W    = 32,
  parameter logic [W-1:0]    POLY = W'(32'h80200003),
  parameter logic [W-1:0]    SEED = W'(32'h00000001)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         step_en,
  input  logic         load_en,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] state
);

  logic [W-1:0] lfsr_q;
  logic [W-1:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (load_en) begin
      lfsr_d = (load_val == '0) ? SEED : load_val;
    end else if (step_en) begin
      // Right-shifting Galois form: the bit shifted out folds the tap mask back in.
      lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? POLY : '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign state = lfsr_q;

endmodule

// File: rtl/prng_accum.sv
// Concatenates successive LFSR states into OUT_W-bit random words behind a valid/ready port.
// Optional range rejection is compiled in with the PRNG_ACCUM_REJECT_EN macro.
module prng_accum
  import prng_pkg::*;
#(
  parameter int                 LFSR_W       = 32,
  parameter int                 OUT_W        = 256,
  parameter logic [LFSR_W-1:0]  POLY         = LFSR_W'(DEF_POLY),
  parameter logic [LFSR_W-1:0]  SEED_DEFAULT = LFSR_W'(DEF_SEED)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed_in,
  input  logic              req,
  input  logic [OUT_W-1:0]  bound,
  prng_accum_if.master      out_if,
  output logic              busy,
  output logic [REJ_W-1:0]  rej_cnt,
  output state_t            dbg_state
);

  localparam int NWORDS = OUT_W / LFSR_W;
  localparam int CNT_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NWORDS - 1);

  state_t             state_q, state_d;
  logic [OUT_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [OUT_W-1:0]   data_q, data_d;
  logic               valid_q, valid_d;
  logic [REJ_W-1:0]   rej_q, rej_d;

  logic               step_en;
  logic [LFSR_W-1:0]  lfsr_state;
  logic [OUT_W-1:0]   candidate;
  logic               reject;

  prng_lfsr_core #(
    .W    (LFSR_W),
    .POLY (POLY),
    .SEED (SEED_DEFAULT)
  ) u_lfsr (
    .clk      (clk),
    .rst_n    (rst_n),
    .step_en  (step_en),
    .load_en  (seed_load),
    .load_val (seed_in),
    .state    (lfsr_state)
  );

  // Shift the current LFSR state in at the bottom so the oldest state ends up in the MSBs.
  assign candidate = OUT_W'({acc_q, lfsr_state});

`ifdef PRNG_ACCUM_REJECT_EN
  assign reject = (candidate == '0) || ((bound != '0) && (candidate >= bound));
`else
  logic unused_bound;
  assign unused_bound = ^bound;
  assign reject       = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    valid_d = valid_q;
    rej_d   = rej_q;
    step_en = 1'b0;

    if (seed_load) begin
      // Reseed drops any pending word, even one being accepted this very cycle.
      state_d = IDLE;
      acc_d   = '0;
      cnt_d   = '0;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req) begin
            state_d = FILL;
            cnt_d   = '0;
          end
        end
        FILL: begin
          step_en = 1'b1;
          acc_d   = candidate;
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            if (reject) begin
              rej_d = sat_inc(rej_q);
            end else begin
              state_d = HOLD;
              data_d  = candidate;
              valid_d = 1'b1;
            end
          end
        end
        HOLD: begin
          if (valid_q && out_if.out_ready) begin
            valid_d = 1'b0;
            cnt_d   = '0;
            state_d = req ? FILL : IDLE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      rej_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      rej_q   <= rej_d;
    end
  end

  assign out_if.out_data  = data_q;
  assign out_if.out_valid = valid_q;
  assign busy             = (state_q == FILL);
  assign rej_cnt          = rej_q;
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_prng_accum.sv
// Self-checking bench for prng_accum: random seeds and ready patterns against a word-level model.
// Covers PRNG_ACCUM_REJECT_EN when the macro is defined, otherwise checks that bound is ignored.
module tb_prng_accum;
  import prng_pkg::*;

  localparam int LW = 32;
  localparam int OW = 256;
  localparam int NW = OW / LW;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          seed_load = 1'b0;
  logic [LW-1:0] seed_in   = '0;
  logic          req       = 1'b0;
  logic [OW-1:0] bound     = '0;
  logic          busy;
  logic [15:0]   rej_cnt;
  state_t        dbg_state;

  prng_accum_if #(.OUT_W(OW)) bus ();

  prng_accum #(.LFSR_W(LW), .OUT_W(OW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .seed_load (seed_load),
    .seed_in   (seed_in),
    .req       (req),
    .bound     (bound),
    .out_if    (bus),
    .busy      (busy),
    .rej_cnt   (rej_cnt),
    .dbg_state (dbg_state)
  );

  int checks = 0;
  int errors = 0;

  // reference model: sequence of LFSR states as polynomial arithmetic over GF(2)
  logic [LW-1:0] m_lfsr;
  logic [OW-1:0] exp_q[$];

  function automatic logic [LW-1:0] m_next(input logic [LW-1:0] s);
    return s[0] ? ((s >> 1) ^ 32'h80200003) : (s >> 1);
  endfunction

  task automatic model_seed(input logic [LW-1:0] v);
    m_lfsr = (v == 0) ? 32'h00000001 : v;
  endtask

  task automatic model_word(output logic [OW-1:0] w);
    w = '0;
    for (int i = 0; i < NW; i++) begin
      w[OW-1-i*LW -: LW] = m_lfsr;
      m_lfsr = m_next(m_lfsr);
    end
  endtask

  task automatic model_push(input int n);
    logic [OW-1:0] w;
    for (int i = 0; i < n; i++) begin
      model_word(w);
      exp_q.push_back(w);
    end
  endtask

  // driver tasks
  task automatic start_seed(input logic [LW-1:0] s);
    @(negedge clk);
    req       = 1'b0;
    seed_load = 1'b1;
    seed_in   = s;
    @(negedge clk);
    seed_load = 1'b0;
  endtask

  task automatic wait_valid(input int budget, output int edges, output bit ok);
    ok    = 1'b0;
    edges = 0;
    while (edges < budget && !ok) begin
      @(posedge clk);
      #1;
      edges++;
      if (bus.out_valid === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", bus.out_valid); end
    checks++;
    if (bus.out_data !== '0) begin errors++; $display("FAIL reset_data got %h want 0", bus.out_data); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
    checks++;
    if (rej_cnt !== 16'h0) begin errors++; $display("FAIL reset_rej got %0d want 0", rej_cnt); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_seed_one();
    int n; bit ok;
    exp_q.delete();
    start_seed(32'h00000001);
    model_seed(32'h00000001);
    model_push(4);
    bus.out_ready = 1'b1;
    req = 1'b1;
    wait_valid(40, n, ok);
    checks++;
    if (!ok || n != NW + 1) begin errors++; $display("FAIL seed1_latency got %0d ok=%0b want %0d", n, ok, NW + 1); end
    checks++;
    if (bus.out_data !== exp_q[0]) begin errors++; $display("FAIL seed1_word0 got %h want %h", bus.out_data, exp_q[0]); end
    void'(exp_q.pop_front());
    for (int i = 1; i < 4; i++) begin
      wait_valid(40, n, ok);
      checks++;
      if (!ok || bus.out_data !== exp_q[0]) begin
        errors++; $display("FAIL seed1_word%0d got %h ok=%0b want %h", i, bus.out_data, ok, exp_q[0]);
      end
      void'(exp_q.pop_front());
    end
  endtask

  task automatic test_zero_seed();
    int n; bit ok;
    exp_q.delete();
    start_seed(32'h00000000);
    model_seed(32'h00000000);
    model_push(3);
    bus.out_ready = 1'b1;
    req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_valid(40, n, ok);
      checks++;
      if (!ok || bus.out_data !== exp_q[0]) begin
        errors++; $display("FAIL zero_seed_word%0d got %h ok=%0b want %h", i, bus.out_data, ok, exp_q[0]);
      end
      void'(exp_q.pop_front());
    end
  endtask

  task automatic test_stall();
    int n; bit ok; logic [OW-1:0] held; logic [LW-1:0] s;
    int bad;
    exp_q.delete();
    s = $urandom;
    start_seed(s);
    model_seed(s);
    model_push(2);
    bus.out_ready = 1'b0;
    req = 1'b1;
    wait_valid(40, n, ok);
    checks++;
    if (!ok || bus.out_data !== exp_q[0]) begin
      errors++; $display("FAIL stall_word0 got %h ok=%0b want %h", bus.out_data, ok, exp_q[0]);
    end
    held = exp_q.pop_front();
    bad = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (bus.out_valid !== 1'b1 || bus.out_data !== held) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL stall_hold unstable_cycles got %0d want 0", bad); end
    @(negedge clk);
    bus.out_ready = 1'b1;
    wait_valid(40, n, ok);
    checks++;
    if (!ok || bus.out_data !== exp_q[0]) begin
      errors++; $display("FAIL stall_word1 got %h ok=%0b want %h", bus.out_data, ok, exp_q[0]);
    end
    void'(exp_q.pop_front());
  endtask

  task automatic test_back_to_back_random();
    logic [LW-1:0] s;
    int cyc;
    exp_q.delete();
    s = $urandom;
    start_seed(s);
    model_seed(s);
    model_push(6);
    req = 1'b1;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 800) begin
      @(negedge clk);
      cyc++;
      bus.out_ready = 1'($urandom_range(0, 1));
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        checks++;
        if (bus.out_data !== exp_q[0]) begin
          errors++; $display("FAIL rand_ready_word got %h want %h", bus.out_data, exp_q[0]);
        end
        void'(exp_q.pop_front());
      end
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL rand_ready_timeout left %0d want 0", exp_q.size()); end
  endtask

  task automatic test_reseed();
    int n; bit ok; int seen; logic [LW-1:0] s;
    exp_q.delete();
    start_seed($urandom);
    bus.out_ready = 1'b1;
    req = 1'b1;
    seen = 0;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (bus.out_valid === 1'b1) seen++;
    end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL reseed_busy got %0b want 1", busy); end
    @(negedge clk);
    seed_load = 1'b1;
    seed_in = 32'h12345678;
    @(negedge clk);
    seed_load = 1'b0;
    model_seed(32'h12345678);
    model_push(1);
    wait_valid(40, n, ok);
    checks++;
    if (seen != 0 || !ok || n != NW + 1) begin
      errors++; $display("FAIL reseed_latency got %0d early=%0d ok=%0b want %0d", n, seen, ok, NW + 1);
    end
    checks++;
    if (bus.out_data !== exp_q[0]) begin errors++; $display("FAIL reseed_word got %h want %h", bus.out_data, exp_q[0]); end
    void'(exp_q.pop_front());

    // reseed collides with a transfer: the word is dropped
    start_seed($urandom);
    bus.out_ready = 1'b0;
    req = 1'b1;
    wait_valid(40, n, ok);
    s = $urandom;
    @(negedge clk);
    bus.out_ready = 1'b1;
    seed_load = 1'b1;
    seed_in = s;
    req = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (!ok || bus.out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL reseed_collide valid=%0b busy=%0b ok=%0b want 0 0 1", bus.out_valid, busy, ok);
    end
    @(negedge clk);
    seed_load = 1'b0;
    req = 1'b1;
    model_seed(s);
    model_push(1);
    wait_valid(40, n, ok);
    checks++;
    if (!ok || bus.out_data !== exp_q[0]) begin
      errors++; $display("FAIL reseed_collide_word got %h ok=%0b want %h", bus.out_data, ok, exp_q[0]);
    end
    void'(exp_q.pop_front());
  endtask

  task automatic test_reset_in_hold();
    int n; bit ok;
    exp_q.delete();
    start_seed($urandom);
    bus.out_ready = 1'b0;
    req = 1'b1;
    wait_valid(40, n, ok);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (!ok || bus.out_valid !== 1'b0 || busy !== 1'b0 || bus.out_data !== '0) begin
      errors++; $display("FAIL hold_reset valid=%0b busy=%0b data=%h ok=%0b want 0 0 0 1", bus.out_valid, busy, bus.out_data, ok);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    model_seed(32'h00000001);
    model_push(2);
    for (int i = 0; i < 2; i++) begin
      wait_valid(40, n, ok);
      checks++;
      if (!ok || bus.out_data !== exp_q[0]) begin
        errors++; $display("FAIL hold_reset_word%0d got %h ok=%0b want %h", i, bus.out_data, ok, exp_q[0]);
      end
      void'(exp_q.pop_front());
    end
  endtask

`ifdef PRNG_ACCUM_REJECT_EN
  task automatic test_reject();
    int n; bit ok; int rejects; int seen; int acc_n;
    logic [OW-1:0] w; logic [LW-1:0] s; logic [15:0] base;
    exp_q.delete();
    s = $urandom;
    start_seed(s);
    model_seed(s);
    bound = '0;
    bound[OW-1] = 1'b1;
    rejects = 0;
    acc_n = 0;
    while (acc_n < 5) begin
      model_word(w);
      if (w == 0 || (bound != 0 && w >= bound)) rejects++;
      else begin exp_q.push_back(w); acc_n++; end
    end
    base = rej_cnt;
    bus.out_ready = 1'b1;
    req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wait_valid(600, n, ok);
      checks++;
      if (!ok || bus.out_data !== exp_q[0] || bus.out_data[OW-1] !== 1'b0) begin
        errors++; $display("FAIL reject_word%0d got %h ok=%0b want %h", i, bus.out_data, ok, exp_q[0]);
      end
      void'(exp_q.pop_front());
    end
    checks++;
    if (16'(rej_cnt - base) !== 16'(rejects)) begin
      errors++; $display("FAIL reject_count got %0d want %0d", 16'(rej_cnt - base), rejects);
    end

    bound = OW'(1);
    start_seed($urandom);
    base = rej_cnt;
    req = 1'b1;
    seen = 0;
    repeat (1 + NW * 6) begin
      @(posedge clk);
      #1;
      if (bus.out_valid === 1'b1) seen++;
    end
    checks++;
    if (seen != 0 || 16'(rej_cnt - base) !== 16'd6) begin
      errors++; $display("FAIL reject_bound1 got rej=%0d valid=%0d want 6 0", 16'(rej_cnt - base), seen);
    end
    bound = '0;
  endtask
`else
  task automatic test_bound_ignored();
    int n; bit ok; logic [LW-1:0] s;
    exp_q.delete();
    bound = OW'(1);
    s = $urandom;
    start_seed(s);
    model_seed(s);
    model_push(2);
    bus.out_ready = 1'b1;
    req = 1'b1;
    for (int i = 0; i < 2; i++) begin
      wait_valid(40, n, ok);
      checks++;
      if (!ok || bus.out_data !== exp_q[0]) begin
        errors++; $display("FAIL bound_ignored_word%0d got %h ok=%0b want %h", i, bus.out_data, ok, exp_q[0]);
      end
      void'(exp_q.pop_front());
    end
    checks++;
    if (rej_cnt !== 16'h0) begin errors++; $display("FAIL bound_ignored_rej got %0d want 0", rej_cnt); end
    bound = '0;
  endtask
`endif

  initial begin
    bus.out_ready = 1'b0;
    test_reset();
    test_seed_one();
    test_zero_seed();
    test_stall();
    test_back_to_back_random();
    test_reseed();
    test_reset_in_hold();
`ifdef PRNG_ACCUM_REJECT_EN
    test_reject();
`else
    test_bound_ignored();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
